mul_issue_arbiter: RTL and testbench
====================================

Name: mul_issue_arbiter

Overview:
Round-robin arbiter and sequencer that shares one multi-cycle, non-pipelined 32-bit multiplier unit (EN/finish handshake, low-32-bit result) among NREQ requesters.
- Accepts one operand pair at a time and pulses the unit's EN for exactly one cycle.
- Waits for finish and returns the result tagged with the requester id over a valid/ready response channel.
- Sits between the issue stage and the multiplier FU in the execution core.

Parameters:
NREQ, 4, number of requesters (2..8).
IDW, 2, requester id width, equals clog2(NREQ).
FU_LAT, 7, FU latency in cycles from EN sampled to finish high; sets the post-reset drain length.

Ports:
clk  in  1  clock, all state on rising edge
rst_n  in  1  asynchronous reset, active-low
req_valid  in  NREQ  per-requester operation request
req_a  in  NREQ*32  packed operand A; slice i = bits [32i+31:32i]
req_b  in  NREQ*32  packed operand B, same packing
req_ready  out  NREQ  one-hot grant; transfer when req_valid[i] & req_ready[i]
resp_valid  out  1  result available
resp_id  out  IDW  requester index of the result
resp_data  out  32  product, low 32 bits
resp_ready  in  1  consumer accepts the result
fu_en  out  1  FU start pulse
fu_a  out  32  FU operand A
fu_b  out  32  FU operand B
fu_res  in  32  FU result
fu_finish  in  1  FU done strobe
busy  out  1  high in every state except IDLE

Behaviour:
- Interface: one clock; reset is asynchronous and active-low.
- Reset (rst_n low, asynchronous) drives the following immediately:
  - state=DRAIN, drain counter=0, rr pointer=0;
  - req_ready=0, resp_valid=0, resp_id=0, resp_data=0;
  - fu_en=0, fu_a=0, fu_b=0, busy=1.
- The FU has no reset, so DRAIN flushes any operation in flight.
- DRAIN:
  - stays for FU_LAT+1 cycles after rst_n deasserts;
  - fu_finish is ignored;
  - req_ready=0;
  - then goes to IDLE.
- IDLE:
  - winner = first i with req_valid[i]=1, searching ptr, ptr+1, ... mod NREQ;
  - req_ready is combinational, one-hot on the winner, and all zero if no request is valid.
  - On handshake:
    - latch A, B and id;
    - ptr <= (winner+1) mod NREQ;
    - go to ISSUE.
- ISSUE:
  - fu_en=1 for exactly this one cycle;
  - fu_a/fu_b come from the latched operands and stay stable until the next grant;
  - next state is WAIT.
- WAIT:
  - fu_en=0;
  - on the first cycle fu_finish=1: resp_data <= fu_res, resp_id <= latched id, resp_valid <= 1, go to RESP.
- RESP:
  - resp_valid, resp_id and resp_data are held stable;
  - on resp_valid & resp_ready: resp_valid <= 0 and go to IDLE.
  - A new grant is possible in the cycle after the response handshake; there is no issue/response overlap.
- Latency, with a FU that raises finish FU_LAT-1 edges after the EN-sampling edge:
  - grant edge E0, fu_en sampled at E1, finish high after E7;
  - resp_valid goes high after edge E0+FU_LAT+1, i.e. 8 cycles with defaults.
- Rules:
  - fu_finish outside WAIT is ignored;
  - req_ready=0 in every state except IDLE;
  - requesters may drop req_valid without penalty when not granted;
  - the pointer advances only on a grant, which gives starvation-free round robin;
  - the product is the low 32 bits of the unsigned/two's-complement product (wraps modulo 2^32).
- State encoding: DRAIN, IDLE, ISSUE, WAIT, RESP. Any illegal encoding returns to DRAIN.

Optional Feature:
MUL_ARB_PERF_EN
- Defined:
  - adds outputs perf_ops (32) and perf_busy (32), both cleared by rst_n;
  - perf_ops increments on each response handshake;
  - perf_busy increments every cycle state is ISSUE, WAIT or RESP;
  - both wrap at 2^32.
- Undefined: the ports and counters are absent; all other behaviour is identical.

Test Plan:
1. Reset release, req_valid=0001 held from the first cycle -> req_ready=0000 for 8 cycles (DRAIN), then grant to 0.
2. Idle, req_valid=0001, a0=6, b0=7, resp_ready=1, FU model with FU_LAT=7 -> single fu_en pulse with fu_a=6, fu_b=7; resp_valid 8 cycles after grant; resp_data=42, resp_id=0; busy low the cycle after the response.
3. All four req_valid held high, resp_ready=1 -> grant order 0,1,2,3,0; exactly one fu_en per grant; resp_id sequence matches.
4. a=0xFFFFFFFF, b=2, resp_ready=0 for 5 cycles after resp_valid -> resp_data=0xFFFFFFFE held stable; req_ready=0 and no fu_en until the response handshake.
5. rst_n pulsed low mid-WAIT -> resp_valid, fu_en and req_ready are 0 immediately; a stale fu_finish during DRAIN produces no response; normal operation resumes after the drain.
6. With MUL_ARB_PERF_EN defined, run 3 back-to-back ops -> perf_ops=3 and perf_busy=3*(FU_LAT+2)=27.

Source files
------------

// File: rtl/mul_issue_arbiter_if.sv
// mul_issue_arbiter_if: request, response and multiplier-FU signal bundle for mul_issue_arbiter
// slave  : the arbiter side (takes requests and FU results, drives grants, responses and FU start/operands)
// master : the environment side (requesters, response consumer and multiplier FU)
interface mul_issue_arbiter_if #(
  parameter int NREQ = 4,
  parameter int IDW  = 2
);
  logic [NREQ-1:0]    req_valid;
  logic [NREQ-1:0]    req_ready;
  logic [NREQ*32-1:0] req_a;
  logic [NREQ*32-1:0] req_b;
  logic               resp_valid;
  logic [IDW-1:0]     resp_id;
  logic [31:0]        resp_data;
  logic               resp_ready;
  logic               fu_en;
  logic [31:0]        fu_a;
  logic [31:0]        fu_b;
  logic [31:0]        fu_res;
  logic               fu_finish;
  modport slave (
    input  req_valid, req_a, req_b, resp_ready, fu_res, fu_finish,
    output req_ready, resp_valid, resp_id, resp_data, fu_en, fu_a, fu_b
  );
  modport master (
    output req_valid, req_a, req_b, resp_ready, fu_res, fu_finish,
    input  req_ready, resp_valid, resp_id, resp_data, fu_en, fu_a, fu_b
  );
endinterface

// File: rtl/mul_issue_arbiter.sv
// mul_issue_arbiter: round-robin sharing of one multi-cycle multiplier FU among NREQ requesters
// Ports: clk, rst_n (async, active-low); bus (mul_issue_arbiter_if.slave: requests, response, FU handshake);
//        busy (high outside IDLE). With MUL_ARB_PERF_EN defined: perf_ops, perf_busy counters.
module mul_issue_arbiter #(
  parameter int NREQ   = 4,
  parameter int IDW    = 2,
  parameter int FU_LAT = 7
) (
  input  logic clk,
  input  logic rst_n,
  mul_issue_arbiter_if.slave bus,
`ifdef MUL_ARB_PERF_EN
  output logic [31:0] perf_ops,
  output logic [31:0] perf_busy,
`endif
  output logic busy
);
  localparam logic [2:0] DRAIN = 3'd0;
  localparam logic [2:0] IDLE  = 3'd1;
  localparam logic [2:0] ISSUE = 3'd2;
  localparam logic [2:0] WAIT  = 3'd3;
  localparam logic [2:0] RESP  = 3'd4;
  localparam int CW = $clog2(FU_LAT + 2);
  logic [2:0]      state;
  logic [CW-1:0]   cnt;
  logic [IDW-1:0]  ptr, win, id, j;
  logic [NREQ-1:0] gnt;
  logic [31:0]     op_a [NREQ];
  logic [31:0]     op_b [NREQ];
  for (genvar i = 0; i < NREQ; i++) begin : g_op
    assign op_a[i] = bus.req_a[32*i +: 32];
    assign op_b[i] = bus.req_b[32*i +: 32];
  end
  // scan from the highest offset down so the first valid requester at or after ptr wins
  always_comb begin
    gnt = '0;
    win = '0;
    j   = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      j = IDW'((int'(ptr) + k) % NREQ);
      if (bus.req_valid[j]) begin
        gnt    = '0;
        gnt[j] = 1'b1;
        win    = j;
      end
    end
  end
  assign bus.req_ready = (state == IDLE) ? gnt : '0;
  assign bus.fu_en     = (state == ISSUE);
  assign busy          = (state != IDLE);
  // the FU has no reset, so DRAIN waits out any operation that may still be in flight
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state          <= DRAIN;
      cnt            <= '0;
      ptr            <= '0;
      id             <= '0;
      bus.resp_valid <= 1'b0;
      bus.resp_id    <= '0;
      bus.resp_data  <= '0;
      bus.fu_a       <= '0;
      bus.fu_b       <= '0;
    end else begin
      cnt <= (state == DRAIN) ? cnt + 1'b1 : '0;
      case (state)
        DRAIN: if (cnt == CW'(FU_LAT)) state <= IDLE;
        IDLE: if (|bus.req_valid) begin
          state    <= ISSUE;
          bus.fu_a <= op_a[win];
          bus.fu_b <= op_b[win];
          id       <= win;
          ptr      <= (win == IDW'(NREQ - 1)) ? '0 : win + 1'b1;
        end
        ISSUE: state <= WAIT;
        WAIT: if (bus.fu_finish) begin
          state          <= RESP;
          bus.resp_data  <= bus.fu_res;
          bus.resp_id    <= id;
          bus.resp_valid <= 1'b1;
        end
        RESP: if (bus.resp_ready) begin
          state          <= IDLE;
          bus.resp_valid <= 1'b0;
        end
        default: state <= DRAIN;
      endcase
    end
`ifdef MUL_ARB_PERF_EN
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      perf_ops  <= '0;
      perf_busy <= '0;
    end else begin
      perf_ops  <= perf_ops + 32'((state == RESP) && bus.resp_ready);
      perf_busy <= perf_busy + 32'((state == ISSUE) || (state == WAIT) || (state == RESP));
    end
`endif
endmodule

// File: tb/tb_mul_issue_arbiter.sv
// tb_mul_issue_arbiter: directed self-checking bench for mul_issue_arbiter with a behavioural FU
module tb_mul_issue_arbiter;
  localparam int NREQ = 4;
  localparam int IDW = 2;
  localparam int FU_LAT = 7;
  logic clk = 1'b0;
  logic rst_n;
  logic busy;
  int checks = 0;
  int failures = 0;
  int en_cnt = 0;
  int fc = 0;
  logic [31:0] exp_data [5];
  logic [1:0] exp_id [5];
  logic seen;
`ifdef MUL_ARB_PERF_EN
  logic [31:0] perf_ops, perf_busy;
`endif
  mul_issue_arbiter_if #(.NREQ(NREQ), .IDW(IDW)) bus ();
  mul_issue_arbiter #(.NREQ(NREQ), .IDW(IDW), .FU_LAT(FU_LAT)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus),
`ifdef MUL_ARB_PERF_EN
    .perf_ops(perf_ops),
    .perf_busy(perf_busy),
`endif
    .busy(busy)
  );
  always #5 clk = ~clk;
  // FU model: captures operands at the EN edge, raises finish FU_LAT-1 edges later, never reset
  initial begin
    bus.fu_finish = 1'b0;
    bus.fu_res = '0;
  end
  always @(posedge clk) begin
    if (bus.fu_en) begin
      fc <= FU_LAT - 1;
      bus.fu_res <= bus.fu_a * bus.fu_b;
    end else if (fc > 0) fc <= fc - 1;
    bus.fu_finish <= (fc == 1) && !bus.fu_en;
    if (bus.fu_en) en_cnt <= en_cnt + 1;
  end
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic setop(input int i, input logic [31:0] a, input logic [31:0] b);
    bus.req_a[32*i +: 32] = a;
    bus.req_b[32*i +: 32] = b;
  endtask
  task automatic wait_resp(input string tag);
    seen = 1'b0;
    for (int k = 0; k < 20 && !seen; k++) begin
      if (bus.resp_valid) seen = 1'b1;
      else tick();
    end
    chk(tag, 64'(seen), 64'd1);
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end
  initial begin
    rst_n = 1'b0;
    bus.req_valid = 4'b0001;
    bus.req_a = '0;
    bus.req_b = '0;
    bus.resp_ready = 1'b1;
    setop(0, 32'd6, 32'd7);
    #12;
    chk("rst_req_ready", 64'(bus.req_ready), 64'd0);
    chk("rst_resp_valid", 64'(bus.resp_valid), 64'd0);
    chk("rst_resp_id", 64'(bus.resp_id), 64'd0);
    chk("rst_resp_data", 64'(bus.resp_data), 64'd0);
    chk("rst_fu_en", 64'(bus.fu_en), 64'd0);
    chk("rst_fu_a", 64'(bus.fu_a), 64'd0);
    chk("rst_fu_b", 64'(bus.fu_b), 64'd0);
    chk("rst_busy", 64'(busy), 64'd1);
`ifdef MUL_ARB_PERF_EN
    chk("rst_perf_ops", 64'(perf_ops), 64'd0);
    chk("rst_perf_busy", 64'(perf_busy), 64'd0);
`endif
    tick();
    rst_n = 1'b1;
    #1;
    chk("drain_ready", 64'(bus.req_ready), 64'd0);
    repeat (7) begin
      tick();
      chk("drain_ready", 64'(bus.req_ready), 64'd0);
    end
    tick();
    chk("idle_grant0", 64'(bus.req_ready), 64'b0001);
    tick();
    bus.req_valid = '0;
    chk("issue_fu_en", 64'(bus.fu_en), 64'd1);
    chk("issue_fu_a", 64'(bus.fu_a), 64'd6);
    chk("issue_fu_b", 64'(bus.fu_b), 64'd7);
    chk("issue_ready", 64'(bus.req_ready), 64'd0);
    chk("issue_busy", 64'(busy), 64'd1);
    tick();
    chk("wait_fu_en", 64'(bus.fu_en), 64'd0);
    repeat (6) begin
      tick();
      chk("wait_no_resp", 64'(bus.resp_valid), 64'd0);
    end
    tick();
    chk("lat_resp_valid", 64'(bus.resp_valid), 64'd1);
    chk("lat_resp_data", 64'(bus.resp_data), 64'd42);
    chk("lat_resp_id", 64'(bus.resp_id), 64'd0);
    tick();
    chk("post_resp_valid", 64'(bus.resp_valid), 64'd0);
    chk("post_busy", 64'(busy), 64'd0);
    chk("single_en", 64'(en_cnt), 64'd1);
    setop(3, 32'hFFFF_FFFF, 32'd2);
    bus.resp_ready = 1'b0;
    bus.req_valid = 4'b1000;
    #1;
    chk("bp_ready3", 64'(bus.req_ready), 64'b1000);
    tick();
    bus.req_valid = '0;
    wait_resp("bp_resp_seen");
    bus.req_valid = 4'b0001;
    repeat (5) begin
      tick();
      chk("bp_hold_valid", 64'(bus.resp_valid), 64'd1);
      chk("bp_hold_data", 64'(bus.resp_data), 64'hFFFF_FFFE);
      chk("bp_hold_id", 64'(bus.resp_id), 64'd3);
      chk("bp_hold_ready", 64'(bus.req_ready), 64'd0);
    end
    chk("bp_en_count", 64'(en_cnt), 64'd2);
    bus.resp_ready = 1'b1;
    tick();
    chk("bp_released", 64'(bus.resp_valid), 64'd0);
    chk("bp_next_ready", 64'(bus.req_ready), 64'b0001);
    bus.req_valid = '0;
    for (int i = 0; i < 4; i++) setop(i, 32'(i + 2), 32'(i + 5));
    exp_id = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
    exp_data = '{32'd10, 32'd18, 32'd28, 32'd40, 32'd10};
    bus.req_valid = 4'b1111;
    for (int n = 0; n < 5; n++) begin
      wait_resp("rr_resp_seen");
      chk("rr_resp_id", 64'(bus.resp_id), 64'(exp_id[n]));
      chk("rr_resp_data", 64'(bus.resp_data), 64'(exp_data[n]));
      if (n == 4) bus.req_valid = '0;
      tick();
    end
    chk("rr_en_count", 64'(en_cnt), 64'd7);
    setop(1, 32'd5, 32'd5);
    bus.req_valid = 4'b0010;
    tick();
    bus.req_valid = '0;
    chk("ar_issue", 64'(bus.fu_en), 64'd1);
    repeat (3) tick();
    rst_n = 1'b0;
    bus.req_valid = 4'b0010;
    #1;
    chk("ar_resp_valid", 64'(bus.resp_valid), 64'd0);
    chk("ar_fu_en", 64'(bus.fu_en), 64'd0);
    chk("ar_ready", 64'(bus.req_ready), 64'd0);
    chk("ar_busy", 64'(busy), 64'd1);
`ifdef MUL_ARB_PERF_EN
    chk("ar_perf_ops", 64'(perf_ops), 64'd0);
`endif
    tick();
    rst_n = 1'b1;
    repeat (7) begin
      tick();
      chk("ar_drain_ready", 64'(bus.req_ready), 64'd0);
      chk("ar_drain_resp", 64'(bus.resp_valid), 64'd0);
    end
    setop(1, 32'd9, 32'd9);
    tick();
    chk("ar_resume_ready", 64'(bus.req_ready), 64'b0010);
    tick();
    bus.req_valid = '0;
    wait_resp("ar_resp_seen");
    chk("ar_resp_data", 64'(bus.resp_data), 64'd81);
    chk("ar_resp_id", 64'(bus.resp_id), 64'd1);
    tick();
    chk("ar_en_count", 64'(en_cnt), 64'd9);
`ifdef MUL_ARB_PERF_EN
    setop(2, 32'd3, 32'd3);
    bus.req_valid = 4'b0100;
    for (int n = 0; n < 3; n++) begin
      wait_resp("perf_resp_seen");
      chk("perf_resp_data", 64'(bus.resp_data), 64'd9);
      if (n == 2) bus.req_valid = '0;
      tick();
    end
    chk("perf_ops", 64'(perf_ops), 64'd4);
    chk("perf_busy", 64'(perf_busy), 64'd36);
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
